// File: rtl/reg_dump_tx.sv
// reg_dump_tx: walks register addresses FIRST_REG..LAST_REG and sends each 32-bit value MSB-byte first as 8N1 UART frames.
// Define REG_DUMP_HEADER_EN to prefix every register with a {3'b000, addr} header byte.
module reg_dump_tx #(
    parameter int unsigned CLK_DIV   = 868,
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_START,
        S_DATA,
        S_STOP,
        S_NEXT
    } state_t;

    localparam logic [15:0] BAUD_MAX   = 16'(CLK_DIV - 1);
    localparam logic [4:0]  ADDR_FIRST = 5'(FIRST_REG);
    localparam logic [4:0]  ADDR_LAST  = 5'(LAST_REG);
`ifdef REG_DUMP_HEADER_EN
    localparam logic [2:0]  BYTE_LAST  = 3'd4;
`else
    localparam logic [2:0]  BYTE_LAST  = 3'd3;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_baud;
    logic [2:0]  r_bit;
    logic [2:0]  r_byte;
    logic [31:0] r_word;
    logic [4:0]  r_addr;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;

    logic        w_tick;
    logic [7:0]  w_cur_byte;
    logic [15:0] w_baud_nxt;
    logic [2:0]  w_bit_nxt;
    logic [2:0]  w_byte_nxt;
    logic [4:0]  w_addr_nxt;
    logic [31:0] w_word_nxt;
    logic        w_tx_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;

    assign w_tick  = (r_baud == BAUD_MAX);
    assign rd_addr = r_addr;
    assign tx      = r_tx;
    assign busy    = r_busy;
    assign done    = r_done;

    always_comb begin
        w_cur_byte = '0;
`ifdef REG_DUMP_HEADER_EN
        case (r_byte)
            3'd0:    w_cur_byte = {3'b000, r_addr};
            3'd1:    w_cur_byte = r_word[31:24];
            3'd2:    w_cur_byte = r_word[23:16];
            3'd3:    w_cur_byte = r_word[15:8];
            3'd4:    w_cur_byte = r_word[7:0];
            default: w_cur_byte = '0;
        endcase
`else
        case (r_byte)
            3'd0:    w_cur_byte = r_word[31:24];
            3'd1:    w_cur_byte = r_word[23:16];
            3'd2:    w_cur_byte = r_word[15:8];
            3'd3:    w_cur_byte = r_word[7:0];
            default: w_cur_byte = '0;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Baud counter clears outside the serial states and on every bit boundary.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = '0;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_addr_nxt  = r_addr;
        w_word_nxt  = r_word;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_word_nxt  = rd_data;
                w_byte_nxt  = '0;
                w_bit_nxt   = '0;
                w_state_nxt = S_START;
            end
            S_START: begin
                if (w_tick) begin
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit == 3'd7) w_state_nxt = S_STOP;
                    else               w_bit_nxt   = r_bit + 3'd1;
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_byte == BYTE_LAST) begin
                        w_state_nxt = S_NEXT;
                    end else begin
                        w_byte_nxt  = r_byte + 3'd1;
                        w_state_nxt = S_START;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            S_NEXT: begin
                if (r_addr == ADDR_LAST) begin
                    w_addr_nxt  = ADDR_FIRST;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_addr_nxt  = r_addr + 5'd1;
                    w_state_nxt = S_CAPTURE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered tx lines up with the state it belongs to.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_cur_byte[w_bit_nxt];
            default: w_tx_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (r_state == S_NEXT) && (w_state_nxt == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_baud <= '0;
            r_bit  <= '0;
            r_byte <= '0;
            r_word <= '0;
            r_addr <= ADDR_FIRST;
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_baud <= w_baud_nxt;
            r_bit  <= w_bit_nxt;
            r_byte <= w_byte_nxt;
            r_word <= w_word_nxt;
            r_addr <= w_addr_nxt;
            r_tx   <= w_tx_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Scoreboard bench for reg_dump_tx: three instances (single reg 29, full 0..31, single reg 2) with UART decoders.
// Expected bytes depend on REG_DUMP_HEADER_EN in the same way as the design.
`timescale 1ns/1ps
module tb_reg_dump_tx;

    localparam int D = 4;
`ifdef REG_DUMP_HEADER_EN
    localparam int B = 5;
`else
    localparam int B = 4;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  start_w = '0;
    logic [2:0]  tx_w;
    logic [2:0]  busy_w;
    logic [2:0]  done_w;
    logic [4:0]  addr0, addr1, addr2;
    logic [31:0] data0, data1, data2;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file models.
    assign data0 = (addr0 == 5'd29) ? 32'h0000_07FC : 32'h0;
    assign data1 = {4{3'b000, addr1}};
    assign data2 = (addr2 == 5'd2) ? 32'hDEAD_BEEF : 32'h0;

    reg_dump_tx #(.CLK_DIV(D), .FIRST_REG(29), .LAST_REG(29)) u_one (
        .clk(clk), .reset(reset), .start(start_w[0]), .rd_addr(addr0), .rd_data(data0),
        .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    reg_dump_tx #(.CLK_DIV(D), .FIRST_REG(0), .LAST_REG(31)) u_full (
        .clk(clk), .reset(reset), .start(start_w[1]), .rd_addr(addr1), .rd_data(data1),
        .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    reg_dump_tx #(.CLK_DIV(D), .FIRST_REG(2), .LAST_REG(2)) u_hdr (
        .clk(clk), .reset(reset), .start(start_w[2]), .rd_addr(addr2), .rd_data(data2),
        .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    typedef struct { int ch; logic [7:0] b; } exp_byte_t;
    typedef struct { int ch; int c; } exp_done_t;
    exp_byte_t  bq[$];
    exp_done_t  dq[$];
    logic [4:0] aq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_b(input int ch, input logic [7:0] b);
        exp_byte_t e;
        e.ch = ch;
        e.b  = b;
        bq.push_back(e);
    endtask

    // Monitors: UART decode per channel, done timing, rd_addr sequence of u_full.
    int         dcnt[3];
    bit         dact[3];
    logic [7:0] dsh[3];
    logic [4:0] prev1 = 5'd0;

    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (!reset) begin
                dact[c] = 1'b0;
            end else if (!dact[c]) begin
                if (tx_w[c] == 1'b0) begin
                    dact[c] = 1'b1;
                    dcnt[c] = 0;
                end
            end else begin
                dcnt[c]++;
                if (dcnt[c] >= D + D/2 && dcnt[c] < 9*D && ((dcnt[c] - D/2) % D) == 0) begin
                    dsh[c] = {tx_w[c], dsh[c][7:1]};
                end else if (dcnt[c] == 9*D + D/2) begin
                    exp_byte_t e;
                    check("stop_bit", 32'(tx_w[c]), 32'd1);
                    if (bq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_byte: ch %0d got 0x%02h expected none", c, dsh[c]);
                    end else begin
                        e = bq.pop_front();
                        check("byte_channel", 32'(c), 32'(e.ch));
                        check("byte_value", 32'(dsh[c]), 32'(e.b));
                    end
                    dact[c] = 1'b0;
                end
            end
            if (reset && done_w[c]) begin
                exp_done_t d;
                check("busy_low_at_done", 32'(busy_w[c]), 32'd0);
                if (dq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: ch %0d at cycle %0d expected none", c, cyc);
                end else begin
                    d = dq.pop_front();
                    check("done_channel", 32'(c), 32'(d.ch));
                    check("done_cycle", 32'(cyc), 32'(d.c));
                end
            end
        end
        if (reset && addr1 !== prev1) begin
            if (aq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_addr: got %0d expected none", addr1);
            end else begin
                check("rd_addr_seq", 32'(addr1), 32'(aq.pop_front()));
            end
        end
        prev1 = addr1;
    end

    // Pulses start for one cycle; N is the cycle whose closing edge samples it.
    task automatic launch(input int ch, input int r);
        exp_done_t d;
        int a;
        @(negedge clk);
        start_w[ch] = 1'b1;
        a = cyc;
        d.ch = ch;
        d.c  = a + 2 + r*B*10*D + 2*(r-1) + 1;
        dq.push_back(d);
        @(negedge clk);
        start_w[ch] = 1'b0;
        check("capture_busy", 32'(busy_w[ch]), 32'd1);
        check("capture_tx", 32'(tx_w[ch]), 32'd1);
        @(negedge clk);
        check("start_bit_at_N2", 32'(tx_w[ch]), 32'd0);
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(negedge clk);
        check("done_pending", 32'(dq.size()), 32'd0);
        check("bytes_pending", 32'(bq.size()), 32'd0);
    endtask

    task automatic push_full();
        for (int k = 0; k < 32; k++) begin
`ifdef REG_DUMP_HEADER_EN
            push_b(1, 8'(k));
`endif
            for (int j = 0; j < 4; j++) push_b(1, 8'(k));
        end
        for (int k = 1; k < 32; k++) aq.push_back(5'(k));
        aq.push_back(5'd0);
    endtask

    task automatic push_reg29();
`ifdef REG_DUMP_HEADER_EN
        push_b(0, 8'h1D);
`endif
        push_b(0, 8'h00);
        push_b(0, 8'h00);
        push_b(0, 8'h07);
        push_b(0, 8'hFC);
    endtask

    initial begin
        bit saw_low;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx_w), 32'h7);
        check("reset_busy", 32'(busy_w), 32'h0);
        check("reset_done", 32'(done_w), 32'h0);
        check("reset_addr_one", 32'(addr0), 32'd29);
        check("reset_addr_full", 32'(addr1), 32'd0);
        check("reset_addr_hdr", 32'(addr2), 32'd2);
        @(negedge clk);
        reset = 1'b1;
        saw_low = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (tx_w != 3'b111 || busy_w != 3'b000) saw_low = 1'b1;
        end
        check("idle_1000_cycles", 32'(saw_low), 32'd0);

        push_reg29();
        launch(0, 1);
        settle(B*10*D + 1 + 20);

        push_full();
        launch(1, 32);
        settle(32*B*10*D + 63 + 20);
        check("addr_seq_pending", 32'(aq.size()), 32'd0);
        check("addr_back_to_first", 32'(addr1), 32'd0);

`ifdef REG_DUMP_HEADER_EN
        push_b(2, 8'h02);
`endif
        push_b(2, 8'hDE);
        push_b(2, 8'hAD);
        push_b(2, 8'hBE);
        push_b(2, 8'hEF);
        launch(2, 1);
        settle(B*10*D + 1 + 20);

        // Second start mid-dump must not add bytes or a second done.
        push_reg29();
        launch(0, 1);
        repeat (50) @(negedge clk);
        start_w[0] = 1'b1;
        repeat (3) @(negedge clk);
        start_w[0] = 1'b0;
        settle(B*10*D + 1 + 20);
        repeat (200) @(negedge clk);
        check("single_done_after_restart", 32'(dq.size()), 32'd0);

        // Reset during DATA of the second frame.
        push_full();
        launch(1, 32);
        repeat (52) @(negedge clk);
        check("tx_low_before_reset", 32'(tx_w[1]), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("async_reset_tx", 32'(tx_w[1]), 32'd1);
        check("async_reset_busy", 32'(busy_w[1]), 32'd0);
        check("async_reset_addr", 32'(addr1), 32'd0);
        bq.delete();
        dq.delete();
        aq.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        push_full();
        launch(1, 32);
        settle(32*B*10*D + 63 + 20);
        check("addr_seq_pending_after_reset", 32'(aq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_dump_tx.md
# reg_dump_tx

Sequential read-out engine for the CPU register file. On a start pulse it walks a configured range of register addresses and drives each address on the register file's read port. It captures the 32-bit read data and shifts it out as 8N1 UART frames on a single `tx` pin. It is the reader/transmitter counterpart of the register file write path and is used for board-level inspection of CPU state.

## Interface
- `CLK_DIV`, 868: clock cycles per UART bit (868 gives 115200 baud at 100 MHz); legal range 2..65535.
- `FIRST_REG`, 0: first register address dumped (0..31).
- `LAST_REG`, 31: last register address dumped; must satisfy `FIRST_REG` ≤ `LAST_REG` ≤ 31.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `start`  in  1  level sampled each cycle; accepted only in IDLE.
- `rd_addr`  out  5  address driven to the register file read port.
- `rd_data`  in  32  combinational read data for `rd_addr`.
- `tx`  out  1  UART serial output; idle high.
- `busy`  out  1  high from the cycle after `start` is accepted until the dump completes.
- `done`  out  1  one-cycle pulse on completion.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `rd_addr`=`FIRST_REG`, state IDLE, all counters 0.
- FSM states:
  - IDLE: `start`=1 leads to CAPTURE.
  - CAPTURE: latch `rd_data` into the 32-bit word register, clear the byte index, then go to START.
  - START: `tx`=0 for `CLK_DIV` cycles, then DATA.
  - DATA: 8 bits, LSB first, `CLK_DIV` cycles each, then STOP.
  - STOP: `tx`=1 for `CLK_DIV` cycles. Next state is START if bytes remain for this register. Otherwise it is NEXT.
  - NEXT: if `rd_addr`==`LAST_REG`, pulse `done`, set `rd_addr`=`FIRST_REG`, go to IDLE. Otherwise increment `rd_addr` and go to CAPTURE.
- Byte order per register: most significant byte first (bits 31:24, then 23:16, 15:8, 7:0).
- Captured data reflects the register file's write bypass: a same-cycle write to `rd_addr` is captured as the new value. Address 0 always reads 0.
- `start` is ignored while `busy`=1. `start` held high after completion begins a new dump on the cycle after `done`.
- Address increment stops at `LAST_REG`, so there is no 5-bit wrap. `FIRST_REG`==`LAST_REG` dumps exactly one register.
- Reset asserted mid-operation immediately forces all reset values, including `tx`=1, even mid-bit. No partial frame completes.

## Timing
- `start` sampled high in cycle N. Cycle N+1 is CAPTURE with `busy`=1. The `tx` falling edge (start bit) occurs in cycle N+2.
- `tx` is driven from a register and is glitch-free.
- Each frame lasts exactly 10×`CLK_DIV` cycles with no gap between frames of one register.
- Each register adds 2 cycles between frames: NEXT, then CAPTURE.
- Total dump length from N+2 to the `done` pulse: R×B×10×`CLK_DIV` + 2×(R−1) + 1 cycles.
  - R = `LAST_REG`−`FIRST_REG`+1.
  - B = bytes per register.
- `busy` falls in the same cycle `done` is high.
- The bit counter and baud counter are internal. The baud counter reloads at every bit boundary.

## Configuration
- `REG_DUMP_HEADER_EN` defined:
  - Each register is prefixed with one header byte, {3'b000, `rd_addr`}, sent before the data bytes.
  - B=5.
- `REG_DUMP_HEADER_EN` undefined:
  - Only the data bytes are sent.
  - B=4.

## Test plan
- Reset and idle: hold `reset`=0, then release. Require `tx`=1, `busy`=0, `done`=0, `rd_addr`=0. `tx` stays 1 with `start`=0 for 1000 cycles.
- Single register, no header: `CLK_DIV`=4, `FIRST_REG`=`LAST_REG`=29, model reg29=0x000007FC, pulse `start`.
  - Decoded bytes must be 0x00, 0x00, 0x07, 0xFC.
  - `tx` falls at N+2.
  - `done` pulses exactly 161 cycles after N+2.
- Full dump: `CLK_DIV`=4, range 0..31, model reg k = k×0x01010101 with reg0=0.
  - Decoded stream must be 128 bytes (160 with `REG_DUMP_HEADER_EN`) in address order.
  - The `rd_addr` sequence must be 0..31, then return to 0.
- Header mode: `REG_DUMP_HEADER_EN` defined, range 2..2, reg2=0xDEADBEEF. Stream must be 0x02, 0xDE, 0xAD, 0xBE, 0xEF.
- Start while busy: pulse `start` again mid-dump. Byte count and `done` timing must be unchanged, and there must be exactly one `done`.
- Reset mid-byte: assert `reset`=0 during DATA of the second byte.
  - `tx`=1 and `busy`=0 asynchronously.
  - After release and a new `start`, the dump restarts from `FIRST_REG` with correct bytes.
